si5340_reg_writer: RTL

Converts a stream of 16-bit-address/8-bit-data Si5340 register writes into byte-level commands for the I2C byte controller (i2c_master_byte command interface). Tracks the Si5340 page register (0x01) and issues a page-select transaction only when the page changes. Sits between the config word source (memory walker / init sequencer) and the byte controller. Reports per-word completion and slave NACKs.

---
 rtl/si5340_reg_writer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/si5340_reg_writer.sv
// Si5340 register writer: turns 16-bit-address register writes into I2C byte
// commands, inserting a page-select write only when the cached page is stale.
module si5340_reg_writer #(
    parameter logic [6:0] SLAVE_ADDR = 7'h74,
    parameter logic [7:0] PAGE_REG   = 8'h01
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        word_valid_i,
    output logic        word_ready_o,
    input  logic [15:0] word_addr_i,
    input  logic [7:0]  word_data_i,
    input  logic        flush_page_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        nack_o,
    output logic [15:0] err_addr_o,
    output logic        cmd_start_o,
    output logic        cmd_stop_o,
    output logic        cmd_read_o,
    output logic        cmd_write_o,
    output logic        cmd_ack_in_o,
    output logic [7:0]  cmd_din_o,
    input  logic        cmd_ack_i,
    input  logic        cmd_ack_out_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_GAP,
        S_ABORT,
        S_ABORT_WAIT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_addr;
    logic [7:0]  r_data;
    logic [1:0]  r_byte;
    logic        r_phase_reg;
    logic [7:0]  r_page;
    logic        r_page_valid;
    logic        r_done;
    logic        r_nack;
    logic [15:0] r_err_addr;
    logic        w_last;
    logic        w_need_page;
    logic [7:0]  w_din;

    assign w_last      = (r_byte == 2'd2);
    assign w_need_page = flush_page_i || !r_page_valid ||
                         (r_page != word_addr_i[15:8]);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (word_valid_i) w_next = S_SEND;
            end
            S_SEND: w_next = S_WAIT;
            S_WAIT: begin
                if (cmd_ack_i) begin
                    if (cmd_ack_out_i)
                        w_next = w_last ? S_IDLE : S_ABORT;
                    else if (w_last && r_phase_reg)
                        w_next = S_IDLE;
                    else
                        w_next = S_GAP;
                end
            end
            S_GAP:   w_next = S_SEND;
            S_ABORT: w_next = S_ABORT_WAIT;
            S_ABORT_WAIT: begin
                if (cmd_ack_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Word datapath, page cache and completion/error reporting
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_addr       <= '0;
            r_data       <= '0;
            r_byte       <= '0;
            r_phase_reg  <= 1'b0;
            r_page       <= '0;
            r_page_valid <= 1'b0;
            r_done       <= 1'b0;
            r_nack       <= 1'b0;
            r_err_addr   <= '0;
        end else begin
            r_done <= 1'b0;
            r_nack <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (flush_page_i) r_page_valid <= 1'b0;
                    if (word_valid_i) begin
                        r_addr      <= word_addr_i;
                        r_data      <= word_data_i;
                        r_byte      <= 2'd0;
                        r_phase_reg <= !w_need_page;
                    end
                end
                S_WAIT: begin
                    if (cmd_ack_i) begin
                        if (cmd_ack_out_i) begin
                            if (w_last) begin
                                r_nack       <= 1'b1;
                                r_err_addr   <= r_addr;
                                r_page_valid <= 1'b0;
                            end
                        end else if (w_last) begin
                            if (r_phase_reg) begin
                                r_done <= 1'b1;
                            end else begin
                                r_page       <= r_addr[15:8];
                                r_page_valid <= 1'b1;
                                r_phase_reg  <= 1'b1;
                                r_byte       <= 2'd0;
                            end
                        end else begin
                            r_byte <= r_byte + 2'd1;
                        end
                    end
                end
                S_ABORT_WAIT: begin
                    if (cmd_ack_i) begin
                        r_nack       <= 1'b1;
                        r_err_addr   <= r_addr;
                        r_page_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_din = 8'h00;
        unique case (r_byte)
            2'd0:    w_din = {SLAVE_ADDR, 1'b0};
            2'd1:    w_din = r_phase_reg ? r_addr[7:0] : PAGE_REG;
            default: w_din = r_phase_reg ? r_data : r_addr[15:8];
        endcase
    end

    always_comb begin
        word_ready_o = (r_state == S_IDLE);
        busy_o       = (r_state != S_IDLE);
        cmd_start_o  = 1'b0;
        cmd_stop_o   = 1'b0;
        cmd_write_o  = 1'b0;
        cmd_din_o    = 8'h00;
        unique case (r_state)
            S_SEND, S_WAIT: begin
                cmd_write_o = 1'b1;
                cmd_start_o = (r_byte == 2'd0);
                cmd_stop_o  = w_last;
                cmd_din_o   = w_din;
            end
            S_ABORT, S_ABORT_WAIT: begin
                cmd_stop_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign done_o       = r_done;
    assign nack_o       = r_nack;
    assign err_addr_o   = r_err_addr;
    assign cmd_read_o   = 1'b0;
    assign cmd_ack_in_o = 1'b0;

endmodule
